// File: rtl/bt_pkg.sv
// Shared balanced-ternary definitions: trit encoding, FSM states and digit helpers.
package bt_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b10;
  localparam trit_t TRIT_BAD  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic trit_t trit_neg(input trit_t t);
    case (t)
      TRIT_POS: return TRIT_NEG;
      TRIT_NEG: return TRIT_POS;
      default:  return TRIT_ZERO;
    endcase
  endfunction

  function automatic logic trit_is_bad(input trit_t t);
    return t == TRIT_BAD;
  endfunction

  // The invalid code behaves as zero everywhere downstream.
  function automatic trit_t trit_clean(input trit_t t);
    return trit_is_bad(t) ? TRIT_ZERO : t;
  endfunction

  function automatic logic signed [2:0] trit_val(input trit_t t);
    case (t)
      TRIT_POS: return 3'sd1;
      TRIT_NEG: return -3'sd1;
      default:  return 3'sd0;
    endcase
  endfunction

endpackage

// File: rtl/bt_trit_adder.sv
// Combinational balanced-ternary full adder: a + b + cin -> sum trit plus carry trit.
module bt_trit_adder
  import bt_pkg::*;
(
  input  trit_t a_i,
  input  trit_t b_i,
  input  trit_t cin_i,
  output trit_t sum_o,
  output trit_t cout_o
);

  logic signed [2:0] s;

  always_comb begin
    s      = trit_val(a_i) + trit_val(b_i) + trit_val(cin_i);
    sum_o  = TRIT_ZERO;
    cout_o = TRIT_ZERO;
    if (s > 3'sd1) begin
      cout_o = TRIT_POS;
      sum_o  = (s == 3'sd2) ? TRIT_NEG : TRIT_ZERO;
    end else if (s < -3'sd1) begin
      cout_o = TRIT_NEG;
      sum_o  = (s == -3'sd2) ? TRIT_POS : TRIT_ZERO;
    end else if (s == 3'sd1) begin
      sum_o = TRIT_POS;
    end else if (s == -3'sd1) begin
      sum_o = TRIT_NEG;
    end
  end

endmodule

// File: rtl/bt_serial_adder.sv
// Digit-serial balanced-ternary adder/subtractor, TRITS_PER_CYCLE trits per clock, LSB first,
// with valid/ready handshakes on both sides.
module bt_serial_adder
  import bt_pkg::*;
#(
  parameter int unsigned NUM_TRITS       = 8,
  parameter int unsigned TRITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*NUM_TRITS-1:0] in_a_i,
  input  logic [2*NUM_TRITS-1:0] in_b_i,
  input  logic                   in_sub_i,
  input  logic [1:0]             in_cin_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*NUM_TRITS-1:0] out_sum_o,
  output logic [1:0]             out_cout_o,
  output logic                   out_err_o
);

  localparam int unsigned STEPS  = NUM_TRITS / TRITS_PER_CYCLE;
  localparam int unsigned StepW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned ChunkW = 2 * TRITS_PER_CYCLE;
  localparam int unsigned VecW   = 2 * NUM_TRITS;
  localparam int unsigned IdxW   = (VecW > 2) ? $clog2(VecW) : 1;

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [VecW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  trit_t            carry_q, carry_d;
  logic             err_q, err_d;

  // Operands are sanitised and B is pre-negated at acceptance so RUN only ever adds.
  logic [VecW-1:0] a_clean, b_clean;
  logic            any_bad;
  trit_t           b_trit;

  always_comb begin
    a_clean = '0;
    b_clean = '0;
    b_trit  = TRIT_ZERO;
    any_bad = trit_is_bad(in_cin_i);
    for (int i = 0; i < int'(NUM_TRITS); i++) begin
      a_clean[2*i +: 2] = trit_clean(in_a_i[2*i +: 2]);
      b_trit            = trit_clean(in_b_i[2*i +: 2]);
      b_clean[2*i +: 2] = in_sub_i ? trit_neg(b_trit) : b_trit;
      any_bad           = any_bad | trit_is_bad(in_a_i[2*i +: 2])
                                  | trit_is_bad(in_b_i[2*i +: 2]);
    end
  end

  logic [IdxW-1:0]                  base;
  trit_t [TRITS_PER_CYCLE-1:0]      chunk_a, chunk_b, chunk_s;
  trit_t                            chain [TRITS_PER_CYCLE+1];

  assign base     = IdxW'(32'(step_q) * ChunkW);
  assign chunk_a  = a_q[base +: ChunkW];
  assign chunk_b  = b_q[base +: ChunkW];
  assign chain[0] = carry_q;

  for (genvar i = 0; i < int'(TRITS_PER_CYCLE); i++) begin : g_trit
    bt_trit_adder u_add (
      .a_i    (chunk_a[i]),
      .b_i    (chunk_b[i]),
      .cin_i  (chain[i]),
      .sum_o  (chunk_s[i]),
      .cout_o (chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_clean;
          b_d     = b_clean;
          carry_d = trit_clean(in_cin_i);
          err_d   = any_bad;
          step_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: ChunkW] = chunk_s;
        carry_d               = chain[TRITS_PER_CYCLE];
        if (step_q == StepW'(STEPS - 1)) begin
          state_d = StDone;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= TRIT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = rst_n && (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign out_sum_o   = sum_q;
  assign out_cout_o  = carry_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_bt_serial_adder.sv
// Bench for bt_serial_adder: 4-trit/1-per-cycle and 8-trit/2-per-cycle instances.
module tb_bt_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_a, in_b;
  logic        in_sub, in_valid, out_ready;
  logic [1:0]  in_cin;
  bit          dsel;

  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [7:0]  sum_a;
  logic [15:0] sum_b;
  logic [1:0]  cout_a, cout_b;

  logic        rdy_s, vld_s, err_s;
  logic [15:0] sum_s;
  logic [1:0]  cout_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bt_serial_adder #(.NUM_TRITS(4), .TRITS_PER_CYCLE(1)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid && !dsel),
    .in_ready_o  (rdy_a),
    .in_a_i      (in_a[7:0]),
    .in_b_i      (in_b[7:0]),
    .in_sub_i    (in_sub),
    .in_cin_i    (in_cin),
    .out_valid_o (vld_a),
    .out_ready_i (out_ready && !dsel),
    .out_sum_o   (sum_a),
    .out_cout_o  (cout_a),
    .out_err_o   (err_a)
  );

  bt_serial_adder #(.NUM_TRITS(8), .TRITS_PER_CYCLE(2)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid && dsel),
    .in_ready_o  (rdy_b),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_sub_i    (in_sub),
    .in_cin_i    (in_cin),
    .out_valid_o (vld_b),
    .out_ready_i (out_ready && dsel),
    .out_sum_o   (sum_b),
    .out_cout_o  (cout_b),
    .out_err_o   (err_b)
  );

  assign rdy_s  = dsel ? rdy_b : rdy_a;
  assign vld_s  = dsel ? vld_b : vld_a;
  assign err_s  = dsel ? err_b : err_a;
  assign sum_s  = dsel ? sum_b : {8'h00, sum_a};
  assign cout_s = dsel ? cout_b : cout_a;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int tv(input logic [1:0] t);
    return (t == 2'b01) ? 1 : (t == 2'b10) ? -1 : 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    return (v == 1) ? 2'b01 : (v == -1) ? 2'b10 : 2'b00;
  endfunction

  // Reference: evaluate both operands as integers, add, then re-express in balanced ternary.
  task automatic model(input int n, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [1:0] cin, output logic [15:0] sum, output logic [1:0] cout,
                       output logic err);
    int v, p, r, tb;
    v = 0;
    p = 1;
    err = (cin == 2'b11);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      tb = sub ? -tv(b[2*i +: 2]) : tv(b[2*i +: 2]);
      v += (tv(a[2*i +: 2]) + tb) * p;
      p *= 3;
      err |= (a[2*i +: 2] == 2'b11) || (b[2*i +: 2] == 2'b11);
    end
    v += tv(cin);
    for (int i = 0; i < n; i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 2) r = -1;
      sum[2*i +: 2] = enc(r);
      v = (v - r) / 3;
    end
    cout = enc(v);
  endtask

  function automatic logic [1:0] rtrit();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 2'b11;
    return (r % 3 == 1) ? 2'b01 : (r % 3 == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!rdy_s && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy_s) chk("in_ready_timeout", 32'(rdy_s), 32'd1);
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [1:0] cin);
    wait_ready();
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!vld_s && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic txn(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic [1:0] cin, output logic [15:0] sum, output logic [1:0] cout,
                     output logic err, output int lat);
    dsel = sel;
    accept(a, b, sub, cin);
    wait_valid(lat);
    sum = sum_s; cout = cout_s; err = err_s;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] a, b;
    logic        sub;
    logic [1:0]  cin;
    logic [15:0] sum;
    logic [1:0]  cout;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] s, es, ra, rb, held;
    logic [1:0]  c, ec, rc;
    logic        e, ee, rs, seen;
    int          lat, n;

    vecs[0]  = '{0, 16'h0015, 16'h0001, 0, 2'b00, 16'h006A, 2'b00, 0};  // 13 + 1
    vecs[1]  = '{0, 16'h0055, 16'h0001, 0, 2'b00, 16'h00AA, 2'b01, 0};  // 40 + 1 overflow
    vecs[2]  = '{0, 16'h001A, 16'h0019, 1, 2'b00, 16'h0009, 2'b00, 0};  // 5 - 7
    vecs[3]  = '{0, 16'h0003, 16'h0001, 0, 2'b00, 16'h0001, 2'b00, 1};  // bad code in A
    vecs[4]  = '{0, 16'h0000, 16'h0000, 0, 2'b01, 16'h0001, 2'b00, 0};  // clean, cin only
    vecs[5]  = '{0, 16'h0002, 16'h0002, 0, 2'b10, 16'h0008, 2'b00, 0};  // -1 + -1 - 1 = -3
    vecs[6]  = '{0, 16'h0000, 16'h0000, 0, 2'b11, 16'h0000, 2'b00, 1};  // bad cin
    vecs[7]  = '{0, 16'h0055, 16'h0055, 1, 2'b00, 16'h0000, 2'b00, 0};  // 40 - 40
    vecs[8]  = '{0, 16'h00AA, 16'h0001, 1, 2'b10, 16'h0054, 2'b10, 0};  // -42 underflow
    vecs[9]  = '{1, 16'h0002, 16'h0002, 0, 2'b10, 16'h0008, 2'b00, 0};  // 8 trits, -3
    vecs[10] = '{1, 16'h5555, 16'h0001, 0, 2'b00, 16'hAAAA, 2'b01, 0};  // 8 trits overflow

    in_a = '0; in_b = '0; in_sub = 0; in_cin = '0; in_valid = 0; out_ready = 0; dsel = 0;

    // Reset state
    #12;
    chk("rst_in_ready_a", 32'(rdy_a), 0);
    chk("rst_in_ready_b", 32'(rdy_b), 0);
    chk("rst_out_valid", 32'(vld_a), 0);
    chk("rst_out_sum", 32'(sum_a), 0);
    chk("rst_out_cout", 32'(cout_a), 0);
    chk("rst_out_err", 32'(err_a), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready_a", 32'(rdy_a), 1);
    chk("post_rst_in_ready_b", 32'(rdy_b), 1);

    foreach (vecs[i]) begin
      txn(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, c, e, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Backpressure: result and in_ready must hold while out_ready is low
    dsel = 0;
    accept(16'h0015, 16'h0001, 0, 2'b00);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    held = sum_s;
    chk("bp_sum", 32'(held), 32'h6A);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_sum_stable", k), 32'(sum_s), 32'(held));
      chk($sformatf("bp%0d_in_ready", k), 32'(rdy_s), 0);
      chk($sformatf("bp%0d_out_valid", k), 32'(vld_s), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle_ready", 32'(rdy_s), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ready_after_ack", 32'(rdy_s), 1);
    chk("bp_valid_after_ack", 32'(vld_s), 0);

    // Reset mid-RUN abandons the operation
    accept(16'h0055, 16'h0001, 0, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_low", 32'(rdy_s), 0);
    chk("midrst_out_valid_low", 32'(vld_s), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(vld_s), 0);
    chk("midrst_in_ready", 32'(rdy_s), 1);
    chk("midrst_sum_cleared", 32'(sum_s), 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen |= vld_s;
    end
    chk("midrst_no_stale_result", 32'(seen), 0);

    // Randomised traffic on both instances
    for (int it = 0; it < 60; it++) begin
      dsel = it[0];
      n = dsel ? 8 : 4;
      ra = '0; rb = '0;
      for (int t = 0; t < n; t++) begin
        ra[2*t +: 2] = rtrit();
        rb[2*t +: 2] = rtrit();
      end
      rs = 1'($urandom_range(0, 1));
      rc = rtrit();
      model(n, ra, rb, rs, rc, es, ec, ee);
      txn(dsel, ra, rb, rs, rc, s, c, e, lat);
      chk($sformatf("rnd%0d_sum", it), 32'(s), 32'(es));
      chk($sformatf("rnd%0d_cout", it), 32'(c), 32'(ec));
      chk($sformatf("rnd%0d_err", it), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
